// File: rtl/mips_divider_pkg.sv
// mips_divider_pkg: shared widths, state encodings and constants for the divider
package mips_divider_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [DEF_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/mips_divider_if.sv
// mips_divider_if: request/result bundle between the issue logic and the divider
interface mips_divider_if import mips_divider_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic start, signed_op, busy, done, div_by_zero;
  logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
  modport master (output start, signed_op, dividend, divisor,
                  input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, signed_op, dividend, divisor,
                 output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/mips_sub33.sv
// mips_sub33: ripple subtractor a - b as a + ~b + 1 over a full-adder chain
module mips_sub33 #(parameter int N = 33) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_n
);
  logic [N:0] c;
  logic [N-1:0] nb;
  assign c[0] = 1'b1;
  assign nb = ~b;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign diff[i] = a[i] ^ nb[i] ^ c[i];
    assign c[i+1] = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
  end
  assign borrow_n = c[N];
endmodule

// File: rtl/mips_divider.sv
// mips_divider: restoring DIV/DIVU unit, one quotient bit per clock
module mips_divider import mips_divider_pkg::*; (
  input logic clk,
  input logic rst_n,
  mips_divider_if.slave bus
);
  localparam int W = DEF_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  state_t state, nxt;
  logic [W:0] rem, sh, diff;
  logic [W-1:0] quo, dvs;
  logic [CW-1:0] cnt;
  logic sa, sb, zp, bn, acc, dz, unused_ok;
  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
    return ~x + W'(1);
  endfunction
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
    return (s && x[W-1]) ? neg(x) : x;
  endfunction
  // zp marks the cycle spent committing a divide-by-zero result before DONE
  assign acc = bus.start && ((state == IDLE && !zp) || state == DONE);
  assign dz = bus.divisor == '0;
  assign sh = {rem[W-1:0], quo[W-1]};
  assign unused_ok = rem[W];
  mips_sub33 #(.N(W + 1)) u_sub (.a(sh), .b({1'b0, dvs}), .diff(diff), .borrow_n(bn));
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    case (state)
      IDLE:    nxt = zp ? DONE : (acc && !dz) ? CALC : IDLE;
      CALC:    nxt = (cnt == LAST) ? FIX : CALC;
      FIX:     nxt = DONE;
      default: nxt = acc ? (dz ? IDLE : CALC) : IDLE;
    endcase
  always_comb begin
    bus.busy = state == CALC || state == FIX;
    bus.done = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      {rem, quo, dvs, cnt, sa, sb, zp} <= '0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      zp <= acc && dz;
      if (acc) begin
        sa <= bus.signed_op && bus.dividend[W-1];
        sb <= bus.signed_op && bus.divisor[W-1];
        quo <= dz ? bus.dividend : mag(bus.dividend, bus.signed_op);
        dvs <= mag(bus.divisor, bus.signed_op);
        rem <= '0;
        cnt <= '0;
        bus.div_by_zero <= 1'b0;
      end else if (zp) begin
        bus.quotient <= DIV_ZERO_QUOTIENT;
        bus.remainder <= quo;
        bus.div_by_zero <= 1'b1;
      end else if (state == CALC) begin
        rem <= bn ? diff : sh;
        quo <= {quo[W-2:0], bn};
        cnt <= cnt + CW'(1);
      end else if (state == FIX) begin
        bus.quotient <= (sa ^ sb) ? neg(quo) : quo;
        bus.remainder <= sa ? neg(rem[W-1:0]) : rem[W-1:0];
      end
    end
endmodule

// File: tb/tb_mips_divider.sv
// tb_mips_divider: directed scoreboard bench for the multi-cycle divider
module tb_mips_divider;
  import mips_divider_pkg::*;
  typedef struct {logic [31:0] q; logic [31:0] r; logic z;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  exp_t sb_q[$];
  exp_t last;
  mips_divider_if bus();
  mips_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    if (b == 0) begin
      e.q = 32'hFFFFFFFF; e.r = a; e.z = 1'b1;
    end else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      e.q = 32'h80000000; e.r = 0; e.z = 1'b0;
    end else if (s) begin
      e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b); e.z = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  // called at a negedge; returns at the negedge just after the accepting edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.dividend = a; bus.divisor = b; bus.signed_op = s; bus.start = 1'b1;
    sb_q.push_back(model(a, b, s));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int k0, input int lat, input int nbusy);
    int k = k0;
    int nb = 0;
    while (!bus.done && k < 100) begin
      if (bus.busy) nb++;
      @(negedge clk);
      k++;
    end
    chk("latency", k, lat);
    chk("busy_cycles", nb, nbusy);
    if (sb_q.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      last = sb_q.pop_front();
      chk("quotient", bus.quotient, last.q);
      chk("remainder", bus.remainder, last.r);
      chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, last.z});
    end
  endtask

  task automatic one(input logic [31:0] a, input logic [31:0] b, input logic s);
    issue(a, b, s);
    wait_done(0, b == 0 ? 1 : 33, b == 0 ? 0 : 33);
    @(negedge clk);
    chk("done_pulse", {31'b0, bus.done}, 0);
    chk("held_quotient", bus.quotient, last.q);
  endtask

  initial begin
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_dbz", {31'b0, bus.div_by_zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    one(100, 7, 1'b0);
    chk("divu_100_7_q", bus.quotient, 14);
    one(32'hFFFFFFF9, 2, 1'b1);
    chk("div_m7_2_q", bus.quotient, 32'hFFFFFFFD);
    chk("div_m7_2_r", bus.remainder, 32'hFFFFFFFF);
    one(7, 32'hFFFFFFFE, 1'b1);
    one(32'h12345678, 0, 1'b0);
    one(1000, 3, 1'b0);
    one(32'h80000000, 32'hFFFFFFFF, 1'b1);
    one(32'hFFFFFFFF, 1, 1'b0);
    one(32'h80000001, 0, 1'b1);
    // start pulsed 10 cycles into CALC must be ignored
    issue(32'd123456, 32'd789, 1'b0);
    repeat (10) @(negedge clk);
    bus.dividend = 5; bus.divisor = 0; bus.signed_op = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(11, 33, 22);
    // back-to-back: new start in the done cycle
    issue(32'hDEADBEEF, 32'h1234, 1'b0);
    wait_done(0, 33, 33);
    issue(32'hFEDCBA98, 32'h00010001, 1'b1);
    wait_done(0, 33, 33);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom >> (i * 8);
      one(a, b, i[0]);
    end
    // reset in the middle of CALC
    issue(32'd999999, 32'd7, 1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb_q.pop_front());
    chk("abort_busy", {31'b0, bus.busy}, 0);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_state", {30'b0, dut.state}, {30'b0, IDLE});
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.done) seen++;
        @(negedge clk);
      end
      chk("abort_no_done", seen, 0);
    end
    one(50, 5, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_divider.md
# mips_divider

Multi-cycle 32-bit integer divider serving the MIPS32 DIV/DIVU instructions; it is the subtract-and-shift counterpart of the ripple-carry adder datapath. It sits beside the ALU. On a single-cycle start pulse it produces quotient (LO) and remainder (HI) through a restoring algorithm, one quotient bit per clock, and signals completion with a one-cycle done pulse. The adder chain is reused in inverted form (b complemented, carry-in 1) as the trial subtractor.

## Interface
- WIDTH, 32: operand width; the iteration count equals WIDTH.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request; sampled only in IDLE or DONE
- signed_op  input  1  1 = DIV (two's complement), 0 = DIVU
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  WIDTH  LO result, held until the next accepted start
- remainder  output  WIDTH  HI result, held until the next accepted start
- div_by_zero  output  1  set with done when divisor was 0

## Operation
- States: IDLE, CALC, FIX, DONE. Encodings are localparams in the shared header.
- IDLE/DONE + start:
  - Latch signed_op and the operand signs.
  - Load the magnitudes |dividend| and |divisor|. In unsigned mode the raw values load unchanged.
  - Clear the partial remainder (WIDTH+1 bits) and set count = 0.
  - If divisor == 0, go directly to DONE.
  - Otherwise go to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left by 1, with the dividend MSB entering rem.
  - Trial = rem − divisor over WIDTH+1 bits.
  - If the trial borrow is clear: rem = trial and quo LSB = 1. Otherwise rem is unchanged and quo LSB = 0.
  - count++. Leave CALC after WIDTH iterations.
- FIX:
  - Negate the quotient if signed_op and the operand signs differ.
  - Negate the remainder if signed_op and the dividend was negative.
  - Register the results and go to DONE.
- DONE: done = 1 for one cycle. Next state is IDLE, or CALC/DONE if start is asserted.
- Divide by zero: quotient = all ones, remainder = dividend as given, div_by_zero = 1.
- Signed overflow (−2^31 / −1): quotient = 0x80000000 (natural wrap), remainder = 0, no flag.
- div_by_zero clears on the next accepted start.
- start during CALC or FIX is ignored, with no queueing.

## Timing
- Reset values: state IDLE; busy, done and div_by_zero 0; quotient and remainder 0; count 0.
- Reset mid-operation aborts the division in the same edge. No done is produced.
- Start accepted at edge N:
  - busy = 1 after edges N through N+32.
  - done = 1 after edge N+33, so latency is 33 cycles from the accepting edge.
- Divide-by-zero start at edge N: done = 1 after edge N+1 and busy never rises.
- Back-to-back: start in the DONE cycle is accepted, giving a throughput of one division per 34 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared header/package holds:
  - state localparams
  - WIDTH default
  - DIV_ZERO_QUOTIENT = all ones
- One sub-module, mips_sub33: a (WIDTH+1)-bit ripple subtractor built from the existing full-adder cell. Inputs are a and ~b, with cin = 1. Outputs are diff and borrow_n.
- The sign handling (two's-complement negate) uses a small function and does not get a separate module.

## Test plan
- DIVU 100 / 7 → quotient 14, remainder 2, done exactly 33 cycles after start, busy high for 33 cycles.
- DIV 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1); DIV 7 / −2 → quotient −3, remainder 1.
- DIVU 0x12345678 / 0 → one cycle to done, quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1; the next valid start clears the flag.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, div_by_zero 0; DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- start pulsed at cycle 10 of CALC with new operands → ignored, and the original result is returned on schedule. start in the DONE cycle → second result after 33 more cycles.
- rst_n low at cycle 15 of CALC → next cycle: busy 0, quotient/remainder 0, state IDLE, and no done pulse appears.
